// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC frame controller: state encoding, code-rate
// enumeration and per-rate geometry lookups.
package ldpc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_LAYER  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_OUTPUT = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2,
    RATE_5_6 = 2'd3
  } code_rate_e;

  localparam int unsigned LAYER_W = 4;
  localparam int unsigned GEOM_W  = 16;

  function automatic logic [GEOM_W-1:0] rate_pick(
    input code_rate_e  rate,
    input int unsigned v0,
    input int unsigned v1,
    input int unsigned v2,
    input int unsigned v3
  );
    logic [GEOM_W-1:0] v;
    case (rate)
      RATE_1_2: v = GEOM_W'(v0);
      RATE_2_3: v = GEOM_W'(v1);
      RATE_3_4: v = GEOM_W'(v2);
      default:  v = GEOM_W'(v3);
    endcase
    return v;
  endfunction

  // Layers per iteration for the given rate.
  function automatic logic [GEOM_W-1:0] layers_of(
    input code_rate_e  rate,
    input int unsigned l0,
    input int unsigned l1,
    input int unsigned l2,
    input int unsigned l3
  );
    return rate_pick(rate, l0, l1, l2, l3);
  endfunction

  // Decoded bits read out for the given rate.
  function automatic logic [GEOM_W-1:0] out_len_of(
    input code_rate_e  rate,
    input int unsigned o0,
    input int unsigned o1,
    input int unsigned o2,
    input int unsigned o3
  );
    return rate_pick(rate, o0, o1, o2, o3);
  endfunction

endpackage

// File: rtl/ldpc_iter_cnt.sv
// Layer and iteration counters: the layer index wraps at the per-rate layer
// count and each wrap bumps the saturating iteration count.
module ldpc_iter_cnt
  import ldpc_pkg::*;
#(
  parameter int unsigned ITER_W    = 5,
  parameter int unsigned LAYERS_R0 = 12,
  parameter int unsigned LAYERS_R1 = 8,
  parameter int unsigned LAYERS_R2 = 6,
  parameter int unsigned LAYERS_R3 = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               adv_i,
  input  code_rate_e         rate_i,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic               last_layer_o,
  output logic [ITER_W-1:0]  num_iter_o
);

  localparam logic [ITER_W-1:0] ITER_MAX = '1;

  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;

  assign last_layer_o = (layer_q == LAYER_W'(layers_of(rate_i, LAYERS_R0, LAYERS_R1,
                                                       LAYERS_R2, LAYERS_R3) - 16'd1));
  assign layer_idx_o  = layer_q;
  assign num_iter_o   = iter_q;

  always_comb begin
    // NOTE: every target gets a default first so no latch is inferred.
    layer_d = layer_q;
    iter_d  = iter_q;
    if (clr_i) begin
      layer_d = '0;
      iter_d  = '0;
    end else if (adv_i) begin
      if (last_layer_o) begin
        layer_d = '0;
        if (iter_q != ITER_MAX) iter_d = iter_q + ITER_W'(1);
      end else begin
        layer_d = layer_q + LAYER_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      layer_q <= '0;
      iter_q  <= '0;
    end else begin
      layer_q <= layer_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: rtl/ldpc_dec_ctrl.sv
// Frame-level LDPC decoder controller: load, layered iterations with early
// termination on a clean syndrome, and hard-decision read-out.
module ldpc_dec_ctrl
  import ldpc_pkg::*;
#(
  parameter  int unsigned FRAME_LEN  = 648,
  parameter  int unsigned PAR        = 1,
  parameter  int unsigned ITER_W     = 5,
  parameter  int unsigned LAYERS_R0  = 12,
  parameter  int unsigned LAYERS_R1  = 8,
  parameter  int unsigned LAYERS_R2  = 6,
  parameter  int unsigned LAYERS_R3  = 4,
  parameter  int unsigned OUT_LEN_R0 = 324,
  parameter  int unsigned OUT_LEN_R1 = 432,
  parameter  int unsigned OUT_LEN_R2 = 486,
  parameter  int unsigned OUT_LEN_R3 = 540,
  localparam int unsigned BEATS      = FRAME_LEN / PAR,
  localparam int unsigned LD_AW      = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned RD_AW      = $clog2(FRAME_LEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sync_in_i,
  input  logic               in_valid_i,
  input  logic [1:0]         code_rate_i,
  input  logic [ITER_W-1:0]  max_iter_i,
  input  logic               layer_done_i,
  input  logic               syn_vld_i,
  input  logic               syn_ok_i,
  output logic [2:0]         fsm_state_o,
  output logic               load_en_o,
  output logic [LD_AW-1:0]   load_addr_o,
  output logic               layer_start_o,
  output logic [LAYER_W-1:0] layer_idx_o,
  output logic               syn_req_o,
  output logic [RD_AW-1:0]   rd_addr_o,
  output logic               out_valid_o,
  output logic               sync_out_o,
  output logic               busy_o,
  output logic               finish_o,
  output logic [ITER_W-1:0]  num_iter_o,
  output logic               early_term_o
);

  localparam logic [LD_AW-1:0] LAST_BEAT = LD_AW'(BEATS - 1);

  state_e            state_q, state_d;
  code_rate_e        rate_q, rate_d;
  logic [ITER_W-1:0] max_iter_q, max_iter_d;
  logic [LD_AW-1:0]  beat_q, beat_d;
  logic [LD_AW-1:0]  load_addr_q, load_addr_d;
  logic [RD_AW-1:0]  rd_addr_q, rd_addr_d;
  logic              load_en_q, load_en_d;
  logic              layer_start_q, layer_start_d;
  logic              syn_req_q, syn_req_d;
  logic              out_valid_q, out_valid_d;
  logic              sync_out_q, sync_out_d;
  logic              busy_q, busy_d;
  logic              finish_q, finish_d;
  logic              early_term_q, early_term_d;

  logic              cnt_clr, cnt_adv, last_layer;
  logic [ITER_W-1:0] num_iter;
  logic [RD_AW-1:0]  last_rd;

  ldpc_iter_cnt #(
    .ITER_W    (ITER_W),
    .LAYERS_R0 (LAYERS_R0),
    .LAYERS_R1 (LAYERS_R1),
    .LAYERS_R2 (LAYERS_R2),
    .LAYERS_R3 (LAYERS_R3)
  ) u_iter_cnt (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (cnt_clr),
    .adv_i        (cnt_adv),
    .rate_i       (rate_q),
    .layer_idx_o  (layer_idx_o),
    .last_layer_o (last_layer),
    .num_iter_o   (num_iter)
  );

  assign last_rd = RD_AW'(out_len_of(rate_q, OUT_LEN_R0, OUT_LEN_R1,
                                     OUT_LEN_R2, OUT_LEN_R3) - 16'd1);

  always_comb begin
    state_d       = state_q;
    rate_d        = rate_q;
    max_iter_d    = max_iter_q;
    beat_d        = beat_q;
    load_addr_d   = load_addr_q;
    rd_addr_d     = rd_addr_q;
    load_en_d     = 1'b0;
    layer_start_d = 1'b0;
    syn_req_d     = 1'b0;
    out_valid_d   = 1'b0;
    sync_out_d    = 1'b0;
    finish_d      = 1'b0;
    early_term_d  = early_term_q;
    cnt_clr       = 1'b0;
    cnt_adv       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sync_in_i && in_valid_i) begin
          rate_d       = code_rate_e'(code_rate_i);
          max_iter_d   = (max_iter_i == '0) ? ITER_W'(1) : max_iter_i;
          cnt_clr      = 1'b1;
          early_term_d = 1'b0;
          load_en_d    = 1'b1;
          load_addr_d  = '0;
          beat_d       = LD_AW'(1);
          if (BEATS == 1) begin
            state_d       = ST_LAYER;
            layer_start_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (in_valid_i) begin
          load_en_d   = 1'b1;
          load_addr_d = beat_q;
          beat_d      = beat_q + LD_AW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d       = ST_LAYER;
            layer_start_d = 1'b1;
          end
        end
      end

      ST_LAYER: state_d = ST_WAIT;

      ST_WAIT: begin
        if (layer_done_i) begin
          cnt_adv = 1'b1;
          if (last_layer) begin
            state_d   = ST_CHECK;
            syn_req_d = 1'b1;
          end else begin
            state_d       = ST_LAYER;
            layer_start_d = 1'b1;
          end
        end
      end

      ST_CHECK: begin
        if (syn_vld_i) begin
          if (!syn_ok_i && (num_iter < max_iter_q)) begin
            state_d       = ST_LAYER;
            layer_start_d = 1'b1;
          end else begin
            // Stopping early only counts when iterations remained unused.
            early_term_d = syn_ok_i && (num_iter < max_iter_q);
            state_d      = ST_OUTPUT;
            out_valid_d  = 1'b1;
            sync_out_d   = 1'b1;
            rd_addr_d    = '0;
          end
        end
      end

      ST_OUTPUT: begin
        if (rd_addr_q == last_rd) begin
          state_d   = ST_IDLE;
          finish_d  = 1'b1;
          rd_addr_d = '0;
        end else begin
          rd_addr_d   = rd_addr_q + RD_AW'(1);
          out_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      rate_q        <= RATE_1_2;
      max_iter_q    <= '0;
      beat_q        <= '0;
      load_addr_q   <= '0;
      rd_addr_q     <= '0;
      load_en_q     <= 1'b0;
      layer_start_q <= 1'b0;
      syn_req_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      sync_out_q    <= 1'b0;
      busy_q        <= 1'b0;
      finish_q      <= 1'b0;
      early_term_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      rate_q        <= rate_d;
      max_iter_q    <= max_iter_d;
      beat_q        <= beat_d;
      load_addr_q   <= load_addr_d;
      rd_addr_q     <= rd_addr_d;
      load_en_q     <= load_en_d;
      layer_start_q <= layer_start_d;
      syn_req_q     <= syn_req_d;
      out_valid_q   <= out_valid_d;
      sync_out_q    <= sync_out_d;
      busy_q        <= busy_d;
      finish_q      <= finish_d;
      early_term_q  <= early_term_d;
    end
  end

  assign fsm_state_o   = state_q;
  assign load_en_o     = load_en_q;
  assign load_addr_o   = load_addr_q;
  assign layer_start_o = layer_start_q;
  assign syn_req_o     = syn_req_q;
  assign rd_addr_o     = rd_addr_q;
  assign out_valid_o   = out_valid_q;
  assign sync_out_o    = sync_out_q;
  assign busy_o        = busy_q;
  assign finish_o      = finish_q;
  assign num_iter_o    = num_iter;
  assign early_term_o  = early_term_q;

endmodule

// File: tb/tb_ldpc_dec_ctrl.sv
// Bench for ldpc_dec_ctrl: random frames scored against a frame-level model,
// with a datapath responder and a decoupled scoreboard monitor.
module tb_ldpc_dec_ctrl;

  localparam int FRAME_LEN = 648;
  localparam int PAR       = 4;
  localparam int ITER_W    = 5;
  localparam int BEATS     = FRAME_LEN / PAR;
  localparam int LD_AW     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RD_AW     = $clog2(FRAME_LEN);
  localparam int MAX_CYC   = 6000;

  int layers_tab[4] = '{12, 8, 6, 4};
  int outlen_tab[4] = '{324, 432, 486, 540};

  typedef struct {
    int rate;
    int iters;
    bit early;
  } frame_t;

  frame_t exp_q[$];

  logic              clk = 1'b0;
  logic              rst;
  logic              sync_in, in_valid, layer_done, syn_vld, syn_ok;
  logic [1:0]        code_rate;
  logic [ITER_W-1:0] max_iter;
  logic [2:0]        fsm_state_o;
  logic              load_en_o, layer_start_o, syn_req_o, out_valid_o;
  logic              sync_out_o, busy_o, finish_o, early_term_o;
  logic [LD_AW-1:0]  load_addr_o;
  logic [3:0]        layer_idx_o;
  logic [RD_AW-1:0]  rd_addr_o;
  logic [ITER_W-1:0] num_iter_o;

  int checks = 0;
  int errors = 0;
  int cur_ok_iter = 0;

  always #5 clk = ~clk;

  ldpc_dec_ctrl #(
    .FRAME_LEN (FRAME_LEN),
    .PAR       (PAR),
    .ITER_W    (ITER_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .sync_in_i     (sync_in),
    .in_valid_i    (in_valid),
    .code_rate_i   (code_rate),
    .max_iter_i    (max_iter),
    .layer_done_i  (layer_done),
    .syn_vld_i     (syn_vld),
    .syn_ok_i      (syn_ok),
    .fsm_state_o   (fsm_state_o),
    .load_en_o     (load_en_o),
    .load_addr_o   (load_addr_o),
    .layer_start_o (layer_start_o),
    .layer_idx_o   (layer_idx_o),
    .syn_req_o     (syn_req_o),
    .rd_addr_o     (rd_addr_o),
    .out_valid_o   (out_valid_o),
    .sync_out_o    (sync_out_o),
    .busy_o        (busy_o),
    .finish_o      (finish_o),
    .num_iter_o    (num_iter_o),
    .early_term_o  (early_term_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {fsm_state_o, load_en_o, layer_start_o, syn_req_o, out_valid_o,
                           sync_out_o, busy_o, finish_o, early_term_o}, 32'd0);
    check({tag, "_cnt"}, {load_addr_o, layer_idx_o, num_iter_o}, 32'd0);
    check({tag, "_rd"}, rd_addr_o, 32'd0);
  endtask

  // Datapath stand-in: answers layer_start and syn_req after random delays,
  // and injects layer_done/syn_vld in states where they must be ignored.
  initial begin : responder
    int ld_wait = -1;
    int sv_wait = -1;
    int iter_seen = 0;
    forever begin
      @(negedge clk);
      layer_done = 1'b0;
      syn_vld    = 1'b0;
      syn_ok     = 1'b0;
      if (rst) begin
        ld_wait = -1;
        sv_wait = -1;
      end else begin
        if (load_en_o && load_addr_o == '0) iter_seen = 0;
        if (layer_start_o) ld_wait = int'($urandom_range(1, 3));
        if (syn_req_o) begin
          iter_seen++;
          sv_wait = int'($urandom_range(0, 2));
        end
        if (ld_wait == 0) layer_done = 1'b1;
        if (sv_wait == 0) begin
          syn_vld = 1'b1;
          syn_ok  = (iter_seen == cur_ok_iter);
        end
        if (ld_wait >= 0) ld_wait--;
        if (sv_wait >= 0) sv_wait--;
        if (!layer_done && fsm_state_o == 3'd4 && $urandom_range(0, 3) == 0) layer_done = 1'b1;
        if (!syn_vld && fsm_state_o == 3'd3 && $urandom_range(0, 3) == 0) begin
          syn_vld = 1'b1;
          syn_ok  = 1'($urandom);
        end
      end
    end
  end

  // Scoreboard: compares DUT activity against the expected frame at the queue head.
  initial begin : monitor
    int ld_cnt = 0;
    int ls_cnt = 0;
    int sr_cnt = 0;
    int out_cnt = 0;
    frame_t f;
    forever begin
      @(negedge clk);
      if (rst) begin
        ld_cnt = 0; ls_cnt = 0; sr_cnt = 0; out_cnt = 0;
        exp_q.delete();
      end else begin
        check("busy", busy_o, fsm_state_o != 3'd0);
        if (load_en_o || layer_start_o || syn_req_o || out_valid_o || finish_o) begin
          if (exp_q.size() == 0) begin
            check("unexpected_activity", 32'd1, 32'd0);
          end else begin
            f = exp_q[0];
            if (load_en_o) begin
              check("load_addr", load_addr_o, ld_cnt);
              ld_cnt++;
            end
            if (layer_start_o) begin
              check("layer_idx", layer_idx_o, ls_cnt % layers_tab[f.rate]);
              ls_cnt++;
            end
            if (syn_req_o) begin
              sr_cnt++;
              check("iter_at_req", num_iter_o, sr_cnt);
            end
            if (out_valid_o) begin
              check("rd_addr", rd_addr_o, out_cnt);
              check("sync_out", sync_out_o, out_cnt == 0);
              out_cnt++;
            end
            if (finish_o) begin
              check("load_beats", ld_cnt, BEATS);
              check("layer_starts", ls_cnt, f.iters * layers_tab[f.rate]);
              check("syn_reqs", sr_cnt, f.iters);
              check("out_beats", out_cnt, outlen_tab[f.rate]);
              check("num_iter", num_iter_o, f.iters);
              check("early_term", early_term_o, f.early);
              exp_q.delete(0);
              ld_cnt = 0; ls_cnt = 0; sr_cnt = 0; out_cnt = 0;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < MAX_CYC; c++) begin
      @(negedge clk);
      if (fsm_state_o == 3'd0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("idle_timeout", 32'd0, 32'd1);
  endtask

  // gap_mode: 0 back-to-back beats, 1 strict 50% toggling, 2 random gaps.
  task automatic run_frame(input int rate, input int mi, input int ok, input int gap_mode,
                           input bit abort_in_wait);
    frame_t f;
    int     eff;
    bit     seen;
    wait_idle(seen);
    if (!seen) return;
    eff     = (mi == 0) ? 1 : mi;
    f.rate  = rate;
    f.iters = (ok != 0 && ok <= eff) ? ok : eff;
    f.early = (ok != 0 && ok < eff);
    exp_q.push_back(f);
    cur_ok_iter = ok;

    sync_in   = 1'b1;
    in_valid  = 1'b1;
    code_rate = 2'(rate);
    max_iter  = ITER_W'(mi);
    for (int b = 1; b < BEATS; b++) begin
      @(negedge clk);
      sync_in   = 1'b0;
      code_rate = 2'($urandom);
      max_iter  = ITER_W'($urandom);
      if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      sync_in  = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    sync_in  = 1'b0;

    seen = 1'b0;
    if (abort_in_wait) begin
      for (int c = 0; c < MAX_CYC; c++) begin
        if (fsm_state_o == 3'd3) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) check("reach_wait", 32'd0, 32'd1);
      #1 rst = 1'b1;
      @(negedge clk);
      #1;
      check_all_zero("mid_reset");
      rst = 1'b0;
      return;
    end

    for (int c = 0; c < MAX_CYC; c++) begin
      @(negedge clk);
      if (finish_o) begin
        seen = 1'b1;
        break;
      end
      if (fsm_state_o >= 3'd2 && $urandom_range(0, 3) == 0) begin
        sync_in   = 1'b1;
        in_valid  = 1'b1;
        code_rate = 2'($urandom);
        max_iter  = ITER_W'($urandom);
      end else begin
        sync_in  = 1'b0;
        in_valid = 1'b0;
      end
    end
    sync_in  = 1'b0;
    in_valid = 1'b0;
    if (!seen) check("finish_timeout", 32'd0, 32'd1);
  endtask

  initial begin : main
    rst       = 1'b1;
    sync_in   = 1'b0;
    in_valid  = 1'b0;
    code_rate = 2'd0;
    max_iter  = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    run_frame(0, 5, 2, 1, 1'b0);
    run_frame(3, 5, 0, 2, 1'b0);
    run_frame(1, 0, 0, 0, 1'b0);
    run_frame(2, 3, 3, 2, 1'b0);
    run_frame(1, 4, 0, 2, 1'b1);
    run_frame(2, 2, 1, 0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
                int'($urandom_range(0, 7)), 2, 1'b0);
    end

    repeat (4) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle limit reached with checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
